cpu_cycle_sequencer: RTL and testbench
======================================

Name: cpu_cycle_sequencer

Overview:
- Parametrised multi-cycle control sequencer for the CPU core. It replaces the fixed 4-phase cycle counter with a handshaked FSM.
- Owns the PC, instruction register and CPSR flags. Evaluates ARM condition codes.
- Stalls on instruction/data memory acknowledge.
- Skips the MEM and WB phases when the instruction does not need them.

Parameters:
- ADDR_W, 32, width of PC and branch target.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, PC increment per retired instruction.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  when 0, FETCH does not issue a new request.
- imem_req  out  1  instruction fetch request, held until acknowledged.
- imem_ack  in  1  fetch complete; imem_rdata is valid this cycle.
- imem_rdata  in  32  fetched instruction.
- pc  out  ADDR_W  address of the current instruction.
- ir  out  32  latched instruction.
- cond_in  in  4  decoded condition field, valid in DECODE.
- is_mem  in  1  decoded: instruction is a load or store.
- is_load  in  1  decoded: load, qualifies is_mem.
- is_branch  in  1  decoded: branch.
- writes_rd  in  1  decoded: result is written to the register file.
- s_bit  in  1  decoded: update flags.
- alu_flags  in  4  NZCV from the ALU, valid in EXEC.
- branch_target  in  ADDR_W  target address, valid in EXEC.
- dmem_req  out  1  data access request, held until acknowledged.
- dmem_ack  in  1  data access complete.
- rf_read_en  out  1  register-file read strobe.
- alu_en  out  1  ALU execute strobe.
- rf_write_en  out  1  register-file write strobe.
- cpsr_flags  out  4  registered NZCV, bit 3 = N.
- link_addr  out  ADDR_W  combinational pc + PC_STEP.
- state  out  3  current FSM state, for the debug port.
- retired_count  out  CNT_W  count of completed instructions.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- Reset (async, immediate):
  - state=FETCH, pc=RESET_PC, ir=0, cpsr_flags=0, retired_count=0.
  - All strobes and requests go to 0 immediately, even mid-handshake.
  - An outstanding memory transaction is abandoned.
- FETCH:
  - imem_req = run.
  - When imem_req && imem_ack: ir<=imem_rdata, then go to DECODE.
  - When run=0, remain in FETCH with imem_req=0.
  - imem_ack without a request is ignored.
- DECODE:
  - rf_read_en=1 for exactly one cycle.
  - cond_pass is evaluated from cond_in against cpsr_flags:
    - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
    - HI C&!Z, LS !C|Z, GE N==V, LT N!=V.
    - GT !Z&(N==V), LE Z|(N!=V), AL 1.
    - 4'b1111 never passes.
  - pass: go to EXEC.
  - fail: retire (skip), then go to FETCH.
- EXEC:
  - alu_en=1 for one cycle.
  - If s_bit: cpsr_flags<=alu_flags at the end of the cycle.
  - Branch: retire with pc<=branch_target.
  - Otherwise, is_mem: go to MEM.
  - Otherwise, writes_rd: go to WB.
  - Otherwise: retire.
- MEM:
  - dmem_req=1 until dmem_ack, holding state.
  - On ack: is_load goes to WB, else retire.
  - dmem_ack outside MEM is ignored.
- WB: rf_write_en=1 for one cycle, then retire.
- Retire (occurs on the exit edge of the last state, next state FETCH):
  - pc<=pc+PC_STEP, or branch_target for a taken branch.
  - The PC add wraps modulo 2^ADDR_W.
  - retired_count+=1, wrapping at 2^CNT_W.
  - Skipped instructions count as retired.
- Latency with zero-wait acknowledges, from entering FETCH to the next FETCH:
  - skipped: 2 cycles.
  - branch or no-write ALU op: 3.
  - ALU op with writeback: 4.
  - store: 4.
  - load: 5.
  - Each memory wait cycle adds 1.
- Decoded inputs are sampled only in the state that uses them. ir is stable from DECODE until the next FETCH acknowledge.
- At most one of rf_read_en, alu_en and rf_write_en is high in any cycle.

Test Plan:
- rst pulse mid-MEM with dmem_req=1 -> dmem_req drops before the next edge; state=0, pc=RESET_PC, retired_count=0, cpsr_flags=0.
- ADD with writes_rd=1, s_bit=1, alu_flags=4'b0100, zero-wait acks -> state sequence 0,1,2,4,0; cpsr_flags=4'b0100; pc=4; retired_count=1.
- cpsr_flags Z=1, cond_in=NE (0001) -> sequence 0,1,0; alu_en never asserted; pc advances by 4; retired_count increments.
- Load with imem_ack delayed 2 cycles and dmem_ack delayed 3 cycles -> imem_req held 3 cycles; dmem_req held 4 cycles; rf_write_en pulses once; total 10 cycles.
- Branch with cond AL and branch_target=0x100 -> pc=0x100 after EXEC; link_addr=0x104 in the next DECODE.
- Counter wrap with CNT_W=4 -> after 16 retired instructions, retired_count=0. Also: run=0 -> imem_req stays 0 and the state stays FETCH.

Source files
------------

// File: rtl/cpu_cycle_sequencer_if.sv
// Purpose : bundles the CPU control sequencer's fetch, decode, execute, memory and debug signals.
// Ports   : master = sequencer side (drives pc/ir/flags/strobes/requests); slave = core/memory side.
// Params  : ADDR_W = PC and branch-target width, CNT_W = retired-instruction counter width.
interface cpu_cycle_sequencer_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic                run;
    logic                imem_req;
    logic                imem_ack;
    logic [31:0]         imem_rdata;
    logic [ADDR_W-1:0]   pc;
    logic [31:0]         ir;
    logic [3:0]          cond_in;
    logic                is_mem;
    logic                is_load;
    logic                is_branch;
    logic                writes_rd;
    logic                s_bit;
    logic [3:0]          alu_flags;
    logic [ADDR_W-1:0]   branch_target;
    logic                dmem_req;
    logic                dmem_ack;
    logic                rf_read_en;
    logic                alu_en;
    logic                rf_write_en;
    logic [3:0]          cpsr_flags;
    logic [ADDR_W-1:0]   link_addr;
    logic [2:0]          state;
    logic [CNT_W-1:0]    retired_count;

    modport master (
        input  run, imem_ack, imem_rdata, cond_in, is_mem, is_load, is_branch,
               writes_rd, s_bit, alu_flags, branch_target, dmem_ack,
        output imem_req, pc, ir, dmem_req, rf_read_en, alu_en, rf_write_en,
               cpsr_flags, link_addr, state, retired_count
    );

    modport slave (
        output run, imem_ack, imem_rdata, cond_in, is_mem, is_load, is_branch,
               writes_rd, s_bit, alu_flags, branch_target, dmem_ack,
        input  imem_req, pc, ir, dmem_req, rf_read_en, alu_en, rf_write_en,
               cpsr_flags, link_addr, state, retired_count
    );
endinterface

// File: rtl/cpu_cycle_sequencer.sv
// Purpose : multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer owning PC, IR, CPSR flags and retire count.
// Latency : zero-wait 2 (skip), 3 (branch / no-write ALU), 4 (ALU+WB, store), 5 (load) cycles FETCH-to-FETCH.
// Backpressure: imem_req/dmem_req are held until the matching ack; every wait cycle stalls the FSM in place.
// Ports   : clk, rst (async, active high) plus io_bus (master modport of cpu_cycle_sequencer_if).
module cpu_cycle_sequencer #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 4,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_cycle_sequencer_if.master io_bus
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [31:0]        r_ir;
    logic [3:0]         r_flags;
    logic [CNT_W-1:0]   r_retired;
    logic               r_rf_read_en;
    logic               r_alu_en;
    logic               r_rf_write_en;
    logic               r_dmem_req;

    logic               w_imem_req;
    logic               w_cond_pass;
    logic [ADDR_W-1:0]  w_link_addr;
    logic               w_n;
    logic               w_z;
    logic               w_c;
    logic               w_v;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    // The fetch request follows run directly so a stopped core never issues a
    // request; rst is folded in so the request drops the instant reset rises.
    assign w_imem_req  = (r_state == ST_FETCH) && io_bus.run && !rst;
    assign w_link_addr = r_pc + ADDR_W'(PC_STEP);

    // ARM condition-code evaluation against the committed flags.
    always_comb begin
        w_cond_pass = 1'b0;
        case (io_bus.cond_in)
            4'h0:    w_cond_pass = w_z;
            4'h1:    w_cond_pass = !w_z;
            4'h2:    w_cond_pass = w_c;
            4'h3:    w_cond_pass = !w_c;
            4'h4:    w_cond_pass = w_n;
            4'h5:    w_cond_pass = !w_n;
            4'h6:    w_cond_pass = w_v;
            4'h7:    w_cond_pass = !w_v;
            4'h8:    w_cond_pass = w_c && !w_z;
            4'h9:    w_cond_pass = !w_c || w_z;
            4'hA:    w_cond_pass = (w_n == w_v);
            4'hB:    w_cond_pass = (w_n != w_v);
            4'hC:    w_cond_pass = !w_z && (w_n == w_v);
            4'hD:    w_cond_pass = w_z || (w_n != w_v);
            4'hE:    w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    // Strobes are registered alongside the state transition that enters the
    // state they belong to, so each is high exactly while the FSM sits there.
    // Every retire path loads the next PC, bumps the counter and returns to FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_FETCH;
            r_pc          <= RESET_PC;
            r_ir          <= '0;
            r_flags       <= '0;
            r_retired     <= '0;
            r_rf_read_en  <= 1'b0;
            r_alu_en      <= 1'b0;
            r_rf_write_en <= 1'b0;
            r_dmem_req    <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_imem_req && io_bus.imem_ack) begin
                        r_ir         <= io_bus.imem_rdata;
                        r_rf_read_en <= 1'b1;
                        r_state      <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_rf_read_en <= 1'b0;
                    if (w_cond_pass) begin
                        r_alu_en <= 1'b1;
                        r_state  <= ST_EXEC;
                    end else begin
                        r_pc      <= w_link_addr;
                        r_retired <= r_retired + CNT_W'(1);
                        r_state   <= ST_FETCH;
                    end
                end
                ST_EXEC: begin
                    r_alu_en <= 1'b0;
                    if (io_bus.s_bit) begin
                        r_flags <= io_bus.alu_flags;
                    end
                    if (io_bus.is_branch) begin
                        r_pc      <= io_bus.branch_target;
                        r_retired <= r_retired + CNT_W'(1);
                        r_state   <= ST_FETCH;
                    end else if (io_bus.is_mem) begin
                        r_dmem_req <= 1'b1;
                        r_state    <= ST_MEM;
                    end else if (io_bus.writes_rd) begin
                        r_rf_write_en <= 1'b1;
                        r_state       <= ST_WB;
                    end else begin
                        r_pc      <= w_link_addr;
                        r_retired <= r_retired + CNT_W'(1);
                        r_state   <= ST_FETCH;
                    end
                end
                ST_MEM: begin
                    if (io_bus.dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        if (io_bus.is_load) begin
                            r_rf_write_en <= 1'b1;
                            r_state       <= ST_WB;
                        end else begin
                            r_pc      <= w_link_addr;
                            r_retired <= r_retired + CNT_W'(1);
                            r_state   <= ST_FETCH;
                        end
                    end
                end
                ST_WB: begin
                    r_rf_write_en <= 1'b0;
                    r_pc          <= w_link_addr;
                    r_retired     <= r_retired + CNT_W'(1);
                    r_state       <= ST_FETCH;
                end
                default: begin
                    r_rf_read_en  <= 1'b0;
                    r_alu_en      <= 1'b0;
                    r_rf_write_en <= 1'b0;
                    r_dmem_req    <= 1'b0;
                    r_state       <= ST_FETCH;
                end
            endcase
        end
    end

    assign io_bus.imem_req      = w_imem_req;
    assign io_bus.pc            = r_pc;
    assign io_bus.ir            = r_ir;
    assign io_bus.dmem_req      = r_dmem_req;
    assign io_bus.rf_read_en    = r_rf_read_en;
    assign io_bus.alu_en        = r_alu_en;
    assign io_bus.rf_write_en   = r_rf_write_en;
    assign io_bus.cpsr_flags    = r_flags;
    assign io_bus.link_addr     = w_link_addr;
    assign io_bus.state         = r_state;
    assign io_bus.retired_count = r_retired;

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Purpose : self-checking bench for cpu_cycle_sequencer with a per-cycle behavioural model.
// Latency : model derives each instruction's cycle-by-cycle state list from the phase rules.
// Backpressure: acks are scheduled by planned cycle index, so the bench never waits on the DUT.
module tb_cpu_cycle_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    cpu_cycle_sequencer_if #(.ADDR_W(32), .CNT_W(4)) bus ();

    cpu_cycle_sequencer #(
        .ADDR_W   (32),
        .RESET_PC (32'h0),
        .PC_STEP  (4),
        .CNT_W    (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [3:0]  cond;
        bit          mem;
        bit          load;
        bit          br;
        bit          wr;
        bit          s;
        logic [3:0]  aflg;
        logic [31:0] tgt;
        int          idly;
        int          ddly;
        bit          noise;
        int          abort_at;
    } ins_t;

    // Architectural model state.
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic [3:0]  m_flags;
    logic [3:0]  m_cnt;

    // Expected values for the cycle currently in progress.
    bit          exp_vld;
    bit          exp_run;
    int          exp_state;
    logic [31:0] exp_pc;
    logic [31:0] exp_ir;
    logic [3:0]  exp_flags;
    logic [3:0]  exp_cnt;

    // Observed DUT activity during the current instruction.
    int obs_imem;
    int obs_dmem;
    int obs_wr;
    int obs_alu;
    int obs_busy;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ins_t mk(input logic [31:0] w, input logic [3:0] c,
                                input bit mem, input bit load, input bit br,
                                input bit wr, input bit s, input logic [3:0] af,
                                input logic [31:0] tg, input int id, input int dd,
                                input bit nz, input int ab);
        ins_t t;
        t.word = w; t.cond = c; t.mem = mem; t.load = load; t.br = br;
        t.wr = wr; t.s = s; t.aflg = af; t.tgt = tg; t.idly = id;
        t.ddly = dd; t.noise = nz; t.abort_at = ab;
        return t;
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (exp_vld) begin
            chk("state",       64'(bus.state),         64'(exp_state));
            chk("imem_req",    64'(bus.imem_req),      64'(exp_state == 0 && exp_run));
            chk("rf_read_en",  64'(bus.rf_read_en),    64'(exp_state == 1));
            chk("alu_en",      64'(bus.alu_en),        64'(exp_state == 2));
            chk("dmem_req",    64'(bus.dmem_req),      64'(exp_state == 3));
            chk("rf_write_en", 64'(bus.rf_write_en),   64'(exp_state == 4));
            chk("pc",          64'(bus.pc),            64'(exp_pc));
            chk("ir",          64'(bus.ir),            64'(exp_ir));
            chk("cpsr",        64'(bus.cpsr_flags),    64'(exp_flags));
            chk("retired",     64'(bus.retired_count), 64'(exp_cnt));
            chk("link_addr",   64'(bus.link_addr),     64'(exp_pc + 32'd4));
            obs_imem += int'(bus.imem_req);
            obs_dmem += int'(bus.dmem_req);
            obs_wr   += int'(bus.rf_write_en);
            obs_alu  += int'(bus.alu_en);
            obs_busy += int'(bus.state != 3'd0);
        end
    end

    task automatic set_exp(input int st);
        exp_state = st;
        exp_pc    = m_pc;
        exp_ir    = m_ir;
        exp_flags = m_flags;
        exp_cnt   = m_cnt;
        exp_vld   = 1'b1;
    endtask

    task automatic idle(input int n, input bit ack);
        for (int i = 0; i < n; i++) begin
            bus.run      = 1'b0;
            bus.imem_ack = ack;
            bus.dmem_ack = ack;
            exp_run      = 1'b0;
            set_exp(0);
            @(posedge clk); #1;
        end
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
    endtask

    // Runs one instruction: builds its expected state list, then drives it.
    task automatic do_instr(input ins_t t);
        int st[$];
        bit pass;
        bit last_mem;
        for (int k = 0; k <= t.idly; k++) st.push_back(0);
        st.push_back(1);
        pass = cond_ok(t.cond, m_flags);
        if (pass) begin
            st.push_back(2);
            if (!t.br) begin
                if (t.mem) begin
                    for (int k = 0; k <= t.ddly; k++) st.push_back(3);
                    if (t.load) st.push_back(4);
                end else if (t.wr) begin
                    st.push_back(4);
                end
            end
        end
        obs_imem = 0; obs_dmem = 0; obs_wr = 0; obs_alu = 0; obs_busy = 0;
        for (int i = 0; i < st.size(); i++) begin
            last_mem = (st[i] == 3) && ((i + 1 == st.size()) || (st[i+1] != 3));
            bus.run           = 1'b1;
            bus.imem_ack      = (st[i] == 0) && (i == t.idly);
            bus.imem_rdata    = bus.imem_ack ? t.word : ~t.word;
            bus.dmem_ack      = (st[i] == 3) ? last_mem : t.noise;
            bus.cond_in       = t.cond;
            bus.is_mem        = t.mem;
            bus.is_load       = t.load;
            bus.is_branch     = t.br;
            bus.writes_rd     = t.wr;
            bus.s_bit         = t.s;
            bus.alu_flags     = t.aflg;
            bus.branch_target = t.tgt;
            exp_run           = 1'b1;
            set_exp(st[i]);
            if (i == t.abort_at) begin
                exp_vld      = 1'b0;
                bus.dmem_ack = 1'b0;
                bus.imem_ack = 1'b0;
                #1;
                chk("abort_dmem_req_before", 64'(bus.dmem_req), 64'd1);
                #2 rst = 1'b1;
                #1;
                chk("abort_dmem_req",  64'(bus.dmem_req),      64'd0);
                chk("abort_state",     64'(bus.state),         64'd0);
                chk("abort_pc",        64'(bus.pc),            64'd0);
                chk("abort_retired",   64'(bus.retired_count), 64'd0);
                chk("abort_cpsr",      64'(bus.cpsr_flags),    64'd0);
                chk("abort_ir",        64'(bus.ir),            64'd0);
                #1 rst = 1'b0;
                @(posedge clk); #1;
                m_pc = 32'h0; m_ir = 32'h0; m_flags = 4'h0; m_cnt = 4'h0;
                return;
            end
            @(posedge clk); #1;
            if (st[i] == 0 && i == t.idly) m_ir = t.word;
            if (st[i] == 2 && t.s) m_flags = t.aflg;
        end
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        m_cnt = m_cnt + 4'd1;
        m_pc  = (pass && t.br) ? t.tgt : m_pc + 32'd4;
    endtask

    logic [3:0] cl [10];
    logic [3:0] fl [10];

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0;
        cl = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd15, 4'd1, 4'd2, 4'd3};
        fl = '{4'b0010, 4'b0110, 4'b1001, 4'b1000, 4'b0000,
               4'b0100, 4'b1111, 4'b0100, 4'b0010, 4'b0001};
        exp_vld = 1'b0; exp_run = 1'b1; exp_state = 0;
        exp_pc = '0; exp_ir = '0; exp_flags = '0; exp_cnt = '0;
        obs_imem = 0; obs_dmem = 0; obs_wr = 0; obs_alu = 0; obs_busy = 0;
        m_pc = 32'h0; m_ir = 32'h0; m_flags = 4'h0; m_cnt = 4'h0;
        rst = 1'b1;
        bus.run = 1'b1; bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        bus.cond_in = 4'hE; bus.is_mem = 1'b0; bus.is_load = 1'b0;
        bus.is_branch = 1'b0; bus.writes_rd = 1'b0; bus.s_bit = 1'b0;
        bus.alu_flags = 4'h0; bus.branch_target = '0; bus.dmem_ack = 1'b0;

        // Reset state, including a suppressed fetch request while run=1.
        #12;
        chk("rst_state",    64'(bus.state),         64'd0);
        chk("rst_pc",       64'(bus.pc),            64'd0);
        chk("rst_ir",       64'(bus.ir),            64'd0);
        chk("rst_cpsr",     64'(bus.cpsr_flags),    64'd0);
        chk("rst_retired",  64'(bus.retired_count), 64'd0);
        chk("rst_imem_req", 64'(bus.imem_req),      64'd0);
        #5 rst = 1'b0;
        @(posedge clk); #1;

        // run=0 with stray acks: no request, no progress.
        idle(3, 1'b1);
        chk("run0_state", 64'(bus.state), 64'd0);
        chk("run0_ir",    64'(bus.ir),    64'd0);

        // ADD with writeback and flag update: 0,1,2,4.
        do_instr(mk(32'hE0912003, 4'hE, 0, 0, 0, 1, 1, 4'b0100, 32'h0, 0, 0, 0, -1));
        chk("add_cpsr",    64'(bus.cpsr_flags),    64'h4);
        chk("add_pc",      64'(bus.pc),            64'h4);
        chk("add_retired", 64'(bus.retired_count), 64'd1);

        // NE with Z=1 is skipped: 0,1.
        do_instr(mk(32'h10812003, 4'h1, 0, 0, 0, 1, 1, 4'b1111, 32'h0, 0, 0, 0, -1));
        chk("skip_pc",      64'(bus.pc),            64'h8);
        chk("skip_retired", 64'(bus.retired_count), 64'd2);
        chk("skip_no_alu",  64'(obs_alu),           64'd0);

        // Load with 2 fetch waits and 3 data waits, stray dmem_ack elsewhere.
        do_instr(mk(32'hE5912000, 4'hE, 1, 1, 0, 1, 0, 4'b0000, 32'h0, 2, 3, 1, -1));
        chk("load_imem_cycles",    64'(obs_imem), 64'd3);
        chk("load_dmem_cycles",    64'(obs_dmem), 64'd4);
        chk("load_wb_pulses",      64'(obs_wr),   64'd1);
        chk("load_nonfetch_cycles", 64'(obs_busy), 64'd7);
        chk("load_ir",             64'(bus.ir),   64'hE5912000);

        // Taken branch.
        do_instr(mk(32'hEA00003C, 4'hE, 0, 0, 1, 0, 0, 4'b0000, 32'h100, 0, 0, 0, -1));
        chk("br_pc",   64'(bus.pc),        64'h100);
        chk("br_link", 64'(bus.link_addr), 64'h104);

        // Store gated by EQ (Z still set), then a flag-setting compare.
        do_instr(mk(32'h05812000, 4'h0, 1, 0, 0, 0, 0, 4'b0000, 32'h0, 0, 0, 0, -1));
        do_instr(mk(32'hE1510002, 4'hE, 0, 0, 0, 0, 1, 4'b1000, 32'h0, 0, 0, 0, -1));
        chk("cmp_cpsr", 64'(bus.cpsr_flags), 64'h8);

        // Condition sweep; brings the retired total to 16 so the counter wraps.
        for (int k = 0; k < 10; k++) begin
            do_instr(mk(32'h00800000 | 32'(k), cl[k], 0, 0, 0, k[0], 1, fl[k],
                        32'h0, k % 2, 0, 0, -1));
            if (cl[k] == 4'd15) chk("nv_no_alu", 64'(obs_alu), 64'd0);
        end
        chk("cnt_wrap", 64'(bus.retired_count), 64'd0);

        // Async reset in the middle of a stalled store.
        do_instr(mk(32'hE5812000, 4'hE, 1, 0, 0, 0, 0, 4'b0000, 32'h0, 0, 5, 0, 4));
        do_instr(mk(32'hE0812003, 4'hE, 0, 0, 0, 1, 0, 4'b0000, 32'h0, 0, 0, 0, -1));
        chk("post_rst_pc",      64'(bus.pc),            64'h4);
        chk("post_rst_retired", 64'(bus.retired_count), 64'd1);

        exp_vld = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
